ldl_cdc_sched_v1: RTL and testbench

LDL_CDC_SCHED_V1 -- requirements
Module: LDL_cdc_sched_v1

---
 rtl/ldl_cdc_sched_v1.sv | 72 +++++++
 tb/tb_ldl_cdc_sched_v1.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldl_cdc_sched_v1.sv
// ldl_cdc_sched_v1: round-robin scheduler sharing one toggle-handshake CDC slot among N requesters.
// A grant latches the winner's data and flips slot_tog; HOLD then spaces transfers by interval+2 cycles.
module ldl_cdc_sched_v1 #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CW-1:0]   interval,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] din,
    output logic [N-1:0]    gnt,
    output logic [DW-1:0]   slot_data,
    output logic [IW-1:0]   slot_id,
    output logic            slot_tog,
    output logic            busy
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [IW-1:0] ptr, win;
    logic hit, grant;

    // first set request after ptr in circular order wins
    always_comb begin
        win = '0;
        hit = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!hit && req[(int'(ptr) + i) % N]) begin
                hit = 1'b1;
                win = IW'((int'(ptr) + i) % N);
            end
        end
    end

    always_comb begin
        grant    = rst && state == IDLE && en && hit;
        gnt      = grant ? N'(1) << win : '0;
        state_nx = state;
        if (grant)
            state_nx = HOLD;
        else if (state == HOLD && cnt >= interval)
            state_nx = IDLE;
    end

    assign busy = state == HOLD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= IW'(N - 1);
            slot_data <= '0;
            slot_id   <= '0;
            slot_tog  <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                slot_data <= din[win*DW +: DW];
                slot_id   <= win;
                slot_tog  <= ~slot_tog;
                ptr       <= win;
                cnt       <= '0;
            end else if (state == HOLD && cnt < interval) begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ldl_cdc_sched_v1.sv
// tb_ldl_cdc_sched_v1: directed scenarios plus random traffic checked against a timing-based model
// (busy window derived from grant cycle and interval, round-robin scan from the last winner).
module tb_ldl_cdc_sched_v1;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic [CW-1:0]   interval = '0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] din = '0;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   slot_data;
    logic [IW-1:0]   slot_id;
    logic            slot_tog;
    logic            busy;

    int total = 0, bad = 0;
    int cyc = 0, m_last = N - 1, m_g = -1000, m_int = 0;
    int m_data = 0, m_id = 0, m_tog = 0;
    int gids[$];
    int gcyc[$];

    always #5 clk = ~clk;

    ldl_cdc_sched_v1 #(.N(N), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .interval(interval), .req(req), .din(din),
        .gnt(gnt), .slot_data(slot_data), .slot_id(slot_id), .slot_tog(slot_tog), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // HOLD occupies the interval+1 cycles following the grant cycle
    function automatic bit m_busy();
        return m_g >= 0 && cyc > m_g && cyc <= m_g + m_int + 1;
    endfunction

    function automatic int m_win();
        if (!en || req == '0 || m_busy()) return -1;
        for (int k = 1; k <= N; k++)
            if (req[(m_last + k) % N]) return (m_last + k) % N;
        return -1;
    endfunction

    // a live change mid-HOLD ends the window once elapsed HOLD cycles reach the new value
    task automatic set_interval(input int v);
        if (m_busy()) m_int = (cyc - m_g - 1 > v) ? cyc - m_g - 1 : v;
        interval = CW'(v);
    endtask

    task automatic step(input string tag, output int w);
        #1;
        w = m_win();
        chk({tag, ".gnt"}, gnt, w < 0 ? 0 : (1 << w));
        chk({tag, ".busy"}, busy, m_busy());
        chk({tag, ".slot_data"}, slot_data, m_data);
        chk({tag, ".slot_id"}, slot_id, m_id);
        chk({tag, ".slot_tog"}, slot_tog, m_tog);
        if (gnt != '0) begin
            gids.push_back($clog2(gnt));
            gcyc.push_back(cyc);
        end
        @(posedge clk);
        if (w >= 0) begin
            m_last = w;
            m_g    = cyc;
            m_int  = interval;
            m_data = din[w*DW +: DW];
            m_id   = w;
            m_tog  = m_tog ^ 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input string tag);
        int w;
        for (int i = 0; i < n; i++) step(tag, w);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        m_last = N - 1;
        m_g    = -1000;
        m_data = 0;
        m_id   = 0;
        m_tog  = 0;
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".gnt"}, gnt, 0);
        chk({tag, ".slot_data"}, slot_data, 0);
        chk({tag, ".slot_id"}, slot_id, 0);
        chk({tag, ".slot_tog"}, slot_tog, 0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int w, c0;
        // reset: gnt stays low even with requests and en
        req = '1;
        en  = 1'b1;
        #3;
        chk("rst.gnt", gnt, 0);
        chk("rst.busy", busy, 0);
        chk("rst.slot_data", slot_data, 0);
        chk("rst.slot_id", slot_id, 0);
        chk("rst.slot_tog", slot_tog, 0);
        @(negedge clk);
        rst = 1'b1;

        // single requester, interval 3
        set_interval(3);
        req = 4'b0001;
        din[7:0] = 8'hA5;
        gids.delete(); gcyc.delete();
        run(16, "single");
        chk("single.count", gids.size(), 4);
        for (int i = 0; i < gids.size(); i++) chk("single.id", gids[i], 0);
        for (int i = 1; i < gcyc.size(); i++) chk("single.spacing", gcyc[i] - gcyc[i-1], 5);
        chk("single.data", slot_data, 8'hA5);
        req = '0;
        run(6, "drain");

        // round-robin fairness from reset, interval 0
        do_reset("rst_rr");
        set_interval(0);
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        gids.delete(); gcyc.delete();
        run(10, "rr");
        chk("rr.count", gids.size(), 5);
        for (int i = 0; i < gids.size(); i++) chk("rr.order", gids[i], i % N);
        for (int i = 1; i < gcyc.size(); i++) chk("rr.spacing", gcyc[i] - gcyc[i-1], 2);

        // skip: after grant to 1, req=1001 yields 3 then 0
        req = '0;
        run(4, "drain");
        req = 4'b0010;
        gids.delete(); gcyc.delete();
        step("skip", w);
        req = 4'b1001;
        run(6, "skip");
        chk("skip.count", gids.size() >= 3, 1);
        if (gids.size() >= 3) begin
            chk("skip.first", gids[0], 1);
            chk("skip.second", gids[1], 3);
            chk("skip.third", gids[2], 0);
        end

        // en gating
        req = '0;
        run(4, "drain");
        en  = 1'b0;
        req = 4'b0010;
        gids.delete(); gcyc.delete();
        run(10, "en_off");
        chk("en_off.grants", gids.size(), 0);
        en = 1'b1;
        c0 = cyc;
        step("en_on", w);
        chk("en_on.count", gids.size(), 1);
        if (gids.size() == 1) begin
            chk("en_on.id", gids[0], 1);
            chk("en_on.cycle", gcyc[0], c0);
        end

        // live interval shortened mid-HOLD
        req = '0;
        run(4, "drain");
        set_interval(10);
        req = 4'b0001;
        gids.delete(); gcyc.delete();
        step("live", w);
        req = 4'b0100;
        run(2, "live");
        set_interval(1);
        run(2, "live");
        chk("live.count", gids.size(), 2);
        if (gids.size() == 2) begin
            chk("live.spacing", gcyc[1] - gcyc[0], 4);
            chk("live.id", gids[1], 2);
        end

        // async reset mid-HOLD
        req = '0;
        run(4, "drain");
        do_reset("rst_pre");
        set_interval(5);
        din[7:0] = 8'h3C;
        req = 4'b0001;
        step("rh", w);
        req = '0;
        run(2, "rh");
        chk("rh.tog_before", slot_tog, 1);
        chk("rh.data_before", slot_data, 8'h3C);
        do_reset("rh_rst");
        req = 4'b1111;
        gids.delete(); gcyc.delete();
        step("rh_after", w);
        chk("rh_after.count", gids.size(), 1);
        if (gids.size() == 1) chk("rh_after.id", gids[0], 0);

        // random traffic obeying the hold-until-granted protocol
        req = '0;
        run(8, "drain");
        for (int i = 0; i < 600; i++) begin
            en = $urandom_range(0, 7) != 0;
            for (int k = 0; k < N; k++)
                if (!req[k] && $urandom_range(0, 2) == 0) begin
                    req[k] = 1'b1;
                    din[k*DW +: DW] = DW'($urandom);
                end
            if ($urandom_range(0, 9) == 0) set_interval($urandom_range(0, 6));
            step("rnd", w);
            if (w >= 0) req[w] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
